// File: rtl/tpu_pkg.sv
// Shared sizing defaults, FSM encoding and small helpers for the TPU result path.
// Latency: none; definitions only.
// Backpressure: none; definitions only.
package tpu_pkg;

    localparam int DEF_ADDRESSSIZE    = 10;
    localparam int DEF_PARTIAL_SUM_BW = 24;
    localparam int DEF_MATRIX_SIZE    = 64;
    localparam int DEF_LANES          = 8;
    localparam int DEF_ROW_BUF_DEPTH  = 2;

    // Readout FSM encoding, kept as plain constants so older tools can consume it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_row_fifo.sv
// Row buffer: DEPTH full result rows with push/pop and an occupancy count.
// Latency: a pushed row is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller guarantees push never lands on a full buffer without a pop.
module result_row_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = DEF_ROW_BUF_DEPTH,
    parameter int WIDTH = DEF_PARTIAL_SUM_BW * DEF_MATRIX_SIZE
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = clog2_min1(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Row storage; no reset needed because head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer wrap and occupancy tracking; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/result_readout_ctrl.sv
// Result SRAM readout: fetch a run of rows into a small buffer and stream each row as LANES-wide beats.
// Latency: start edge -> read strobe next cycle -> data captured one edge later -> first beat valid 3 cycles after start.
// Backpressure: valid/ready on beats; payload holds while stalled, reads stop once buffered + in-flight rows fill the buffer.
module result_readout_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int LANES          = DEF_LANES,
    parameter int ROW_BUF_DEPTH  = DEF_ROW_BUF_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ADDRESSSIZE:0]                  num_rows,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  sram_rd_en,
    output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PARTIAL_SUM_BW*LANES-1:0]       out_data,
    output logic                                  out_last,
    output logic [ADDRESSSIZE-1:0]                out_row_idx
);

    localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int BEAT_W = PARTIAL_SUM_BW * LANES;
    localparam int BEATS  = MATRIX_SIZE / LANES;
    localparam int BW     = clog2_min1(BEATS);
    localparam int CW     = $clog2(ROW_BUF_DEPTH + 1);
    localparam int CW1    = CW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW:0]   DEPTH_L   = CW1'(ROW_BUF_DEPTH);

    logic [1:0]             state;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   num_q;
    logic [ADDRESSSIZE:0]   rows_issued;
    logic [ADDRESSSIZE:0]   rows_popped;
    logic [BW-1:0]          beat_cnt;
    logic                   inflight;
    logic [CW-1:0]          fifo_count;
    logic [ROW_W-1:0]       head_row;
    logic [CW:0]            occupancy;
    logic                   start_acc;
    logic                   accept;
    logic                   last_beat;
    logic                   last_row;
    logic                   pop;

    assign start_acc = (state == ST_IDLE) && start;
    // A read is in flight for exactly one cycle, so it counts against buffer space until it lands.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};

    assign sram_rd_en   = (state == ST_RUN) && (rows_issued < num_q) && (occupancy < DEPTH_L);
    assign sram_rd_addr = base_q + rows_issued[ADDRESSSIZE-1:0];

    assign out_valid   = (state == ST_RUN) && (fifo_count != '0);
    assign accept      = out_valid && out_ready;
    assign last_beat   = (beat_cnt == LAST_BEAT);
    assign last_row    = (rows_popped == num_q - 1'b1);
    assign pop         = accept && last_beat;
    assign out_last    = out_valid && last_beat && last_row;
    assign out_data    = out_valid ? head_row[int'(beat_cnt) * BEAT_W +: BEAT_W] : '0;
    assign out_row_idx = rows_popped[ADDRESSSIZE-1:0];

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    result_row_fifo #(
        .DEPTH (ROW_BUF_DEPTH),
        .WIDTH (ROW_W)
    ) u_row_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data (sram_rd_data),
        .pop       (pop),
        .head      (head_row),
        .count     (fifo_count)
    );

    // Job sequencing: empty jobs go straight to the done state; start is ignored outside IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= (num_rows != '0) ? ST_RUN : ST_FIN;
                ST_RUN:  if (accept && out_last) state <= ST_FIN;
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Job parameters and issue/beat/row counters; all restart on an accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q      <= '0;
            num_q       <= '0;
            rows_issued <= '0;
            rows_popped <= '0;
            beat_cnt    <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= sram_rd_en;
            if (start_acc) begin
                base_q      <= base_addr;
                num_q       <= num_rows;
                rows_issued <= '0;
                rows_popped <= '0;
                beat_cnt    <= '0;
            end else begin
                if (sram_rd_en) begin
                    rows_issued <= rows_issued + 1'b1;
                end
                if (accept) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                end
                if (pop) begin
                    rows_popped <= rows_popped + 1'b1;
                end
            end
        end
    end

endmodule
